key_schedule_ctrl: RTL

Sequences the team's combinational single-round key_expansion block to produce all 11 AES-128 round keys, one round per clock. The round keys are stored in an internal register file and exposed through a random-access read port to the round datapath. The block sits between the key-load interface and the encryption/decryption round controllers. Decryption reads the keys in reverse order from the same store.

---
 rtl/aes_pkg.sv | 72 +++++++
 rtl/key_expansion.sv | 32 +++
 rtl/key_schedule_ctrl.sv | 99 +++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 constants, controller state type and GF(2^8) helpers
// used by the key-schedule controller and its key_expansion round block.
package aes_pkg;

    localparam int NR   = 10;
    localparam int NK   = 4;
    localparam int KEYW = 128;
    localparam int IDXW = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        READY  = 2'd2
    } state_e;

    localparam logic [7:0] RCON [NR] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0 as the S-box needs.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] sq;
        r  = 8'h01;
        sq = a;
        for (int i = 0; i < 7; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl1(input logic [7:0] b);
        return {b[6:0], b[7]};
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        logic [7:0] r1;
        logic [7:0] r2;
        logic [7:0] r3;
        logic [7:0] r4;
        b  = gf_inv(a);
        r1 = rotl1(b);
        r2 = rotl1(r1);
        r3 = rotl1(r2);
        r4 = rotl1(r3);
        return b ^ r1 ^ r2 ^ r3 ^ r4 ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

endpackage

// File: rtl/key_expansion.sv
// Combinational single-round AES-128 key expansion: derives round key
// count+1 from round key count.
module key_expansion
    import aes_pkg::*;
(
    input  logic [KEYW-1:0] key,
    input  logic [IDXW-1:0] count,
    output logic [KEYW-1:0] round_key
);

    localparam int WW = KEYW / NK;

    logic [WW-1:0] w0, w1, w2, w3;
    logic [WW-1:0] temp;
    logic [WW-1:0] n0, n1, n2, n3;
    logic [7:0]    rc;

    always_comb begin
        w0 = key[127:96];
        w1 = key[95:64];
        w2 = key[63:32];
        w3 = key[31:0];
        rc = (count < IDXW'(NR)) ? RCON[count] : 8'h00;
        temp = sub_word({w3[23:0], w3[31:24]}) ^ {rc, 24'h000000};
        n0 = w0 ^ temp;
        n1 = w1 ^ n0;
        n2 = w2 ^ n1;
        n3 = w3 ^ n2;
        round_key = {n0, n1, n2, n3};
    end

endmodule

// File: rtl/key_schedule_ctrl.sv
// Runs key_expansion once per clock to fill an 11-entry round-key store,
// and serves the store through a combinational random-access read port.
module key_schedule_ctrl
    import aes_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [KEYW-1:0] key_in,
    input  logic            key_valid,
    output logic            key_ready,
    output logic            busy,
    output logic            done,
    output logic            keys_valid,
    input  logic [IDXW-1:0] rk_idx,
    output logic [KEYW-1:0] rk_out,
    output logic            rk_avail
);

    // key_valid/key_ready: a key transfers on a rising edge where both are high;
    // key_ready is low only while expanding and key_valid is then ignored.

    state_e          state, state_nxt;
    logic [IDXW-1:0] cnt;
    logic [IDXW-1:0] cnt_inc;
    logic [IDXW-1:0] written_ptr;
    logic [KEYW-1:0] store [NR+1];
    logic [KEYW-1:0] exp_key;
    logic            accept;
    logic            last_round;

    key_expansion u_key_expansion (
        .key       (store[cnt]),
        .count     (cnt),
        .round_key (exp_key)
    );

    assign cnt_inc    = cnt + IDXW'(1);
    assign last_round = (cnt == IDXW'(NR - 1));
    assign accept     = key_valid && key_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        key_ready = 1'b1;
        busy      = 1'b0;
        case (state)
            IDLE, READY: begin
                if (accept) state_nxt = EXPAND;
            end
            EXPAND: begin
                key_ready = 1'b0;
                busy      = 1'b1;
                if (last_round) state_nxt = READY;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            written_ptr <= '0;
            done        <= 1'b0;
            keys_valid  <= 1'b0;
            for (int i = 0; i <= NR; i++) store[i] <= '0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                store[0]    <= key_in;
                cnt         <= '0;
                written_ptr <= '0;
                keys_valid  <= 1'b0;
            end else if (state == EXPAND) begin
                store[cnt_inc] <= exp_key;
                cnt            <= cnt_inc;
                written_ptr    <= cnt_inc;
                if (last_round) begin
                    done       <= 1'b1;
                    keys_valid <= 1'b1;
                end
            end
        end
    end

    // Entries beyond written_ptr may still hold the previous key's schedule; rk_avail hides them.
    always_comb begin
        rk_out   = '0;
        rk_avail = 1'b0;
        if (rk_idx <= IDXW'(NR)) begin
            rk_out   = store[rk_idx];
            rk_avail = (state != IDLE) && (rk_idx <= written_ptr);
        end
    end

endmodule
